niosii_soc_onchip_memory_arbiter: RTL and testbench

NIOSII_SOC_ONCHIP_MEMORY_ARBITER -- requirements
Module: niosii_soc_onchip_memory_arbiter

---
 rtl/niosii_soc_onchip_memory_arbiter_pkg.sv | 19 +
 rtl/niosii_soc_rr_hold_grant.sv | 33 +++
 rtl/niosii_soc_onchip_memory_arbiter.sv | 148 ++++++++++++++
 tb/tb_niosii_soc_onchip_memory_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/niosii_soc_onchip_memory_arbiter_pkg.sv
// Shared encodings for the two-master on-chip memory arbiter.
package niosii_soc_onchip_memory_arbiter_pkg;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } owner_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_PEND = 1'b1
    } arb_state_e;

    // hold_cnt must represent 0..MAX_HOLD inclusive.
    function automatic int hold_cnt_w(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/niosii_soc_rr_hold_grant.sv
// Two-master grant: the owner keeps a contended bus for up to MAX_HOLD transfers.
module niosii_soc_rr_hold_grant
    import niosii_soc_onchip_memory_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = hold_cnt_w(MAX_HOLD)
) (
    input  logic [1:0]        req,
    input  owner_e            owner,
    input  logic [HOLD_W-1:0] hold_cnt,
    output logic [1:0]        grant
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    logic owner_req;
    logic keep;

    // hold_cnt == 0 means the owner has no running tenure (idle or fresh from
    // reset), so under contention the other master goes first.
    always_comb begin
        owner_req = (owner == OWNER_M1) ? req[1] : req[0];
        keep      = owner_req && (hold_cnt != '0) && (hold_cnt < MAX_HOLD_C);
        grant     = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (((owner == OWNER_M1) ? 1'b1 : 1'b0) ^ !keep) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/niosii_soc_onchip_memory_arbiter.sv
// Arbitrates two Avalon-MM masters onto one single-port on-chip RAM with 1-cycle read latency.
// Handshake: a command is accepted in a cycle where mN_read|mN_write is high and mN_waitrequest is low.
module niosii_soc_onchip_memory_arbiter
    import niosii_soc_onchip_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,

    output arb_state_e          dbg_state,
    output owner_e              dbg_owner,
    output logic [7:0]          dbg_hold_cnt
);

    localparam int                HOLD_W     = hold_cnt_w(MAX_HOLD);
    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    owner_e            owner_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    arb_state_e        state_q, state_d;
    owner_e            tag_q, tag_d;

    logic [1:0] req;
    logic [1:0] grant_raw;
    logic [1:0] grant;
    logic       accepted;
    owner_e     grantee;
    logic       grant_read;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    niosii_soc_rr_hold_grant #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_grant (
        .req      (req),
        .owner    (owner_q),
        .hold_cnt (hold_cnt_q),
        .grant    (grant_raw)
    );

    // Nothing is accepted while reset is held, so a read issued then never returns.
    assign grant    = reset_n ? grant_raw : 2'b00;
    assign accepted = |grant;
    assign grantee  = grant[1] ? OWNER_M1 : OWNER_M0;

    assign m0_waitrequest = !reset_n || (req[0] && !grant[0]);
    assign m1_waitrequest = !reset_n || (req[1] && !grant[1]);

    // Read with write asserted counts as a write only.
    always_comb begin
        grant_read     = 1'b0;
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_write      = 1'b0;
        if (grant[1]) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
            grant_read     = m1_read && !m1_write;
        end else if (grant[0]) begin
            mem_write      = m0_write;
            grant_read     = m0_read && !m0_write;
        end
    end

    assign mem_chipselect = accepted;
    assign mem_clken      = reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q    <= OWNER_M1;
            hold_cnt_q <= '0;
        end else if (accepted) begin
            if (grantee == owner_q) begin
                if (hold_cnt_q != MAX_HOLD_C) begin
                    hold_cnt_q <= hold_cnt_q + 1'b1;
                end
            end else begin
                owner_q    <= grantee;
                hold_cnt_q <= HOLD_W'(1);
            end
        end else begin
            hold_cnt_q <= '0;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        tag_d   = tag_q;
        if (grant_read) begin
            state_d = ST_RD_PEND;
            tag_d   = grantee;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            tag_q   <= OWNER_M0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    // Read data is broadcast; only the valid strobe follows the registered tag.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = (state_q == ST_RD_PEND) && (tag_q == OWNER_M0);
    assign m1_readdatavalid = (state_q == ST_RD_PEND) && (tag_q == OWNER_M1);

    assign dbg_state    = state_q;
    assign dbg_owner    = owner_q;
    assign dbg_hold_cnt = 8'(hold_cnt_q);

endmodule

// File: tb/tb_niosii_soc_onchip_memory_arbiter.sv
// Directed bench: drivers push expected read returns, a negedge monitor pops and compares them.
module tb_niosii_soc_onchip_memory_arbiter;
    import niosii_soc_onchip_memory_arbiter_pkg::*;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int EXP_W  = 16 + 1 + DATA_W;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [EXP_W-1:0] exp_q[$];

    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [3:0]        m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    arb_state_e        dbg_state;
    owner_e            dbg_owner;
    logic [7:0]        dbg_hold_cnt;

    logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];

    // Second instance with MAX_HOLD = 1; only arbitration is observed.
    logic              h_m0_read, h_m1_read;
    logic              h_m0_wait, h_m1_wait;
    logic [DATA_W-1:0] h_m0_rdata, h_m1_rdata;
    logic              h_m0_rdv, h_m1_rdv;
    logic [ADDR_W-1:0] h_mem_address;
    logic [3:0]        h_mem_be;
    logic [DATA_W-1:0] h_mem_wdata;
    logic              h_mem_cs, h_mem_write, h_mem_clken;
    logic [DATA_W-1:0] h_mem_rdata = '0;
    arb_state_e        h_state;
    owner_e            h_owner;
    logic [7:0]        h_hold;
    logic [ADDR_W-1:0] zero_addr = '0;
    logic [3:0]        zero_be = '0;
    logic [DATA_W-1:0] zero_data = '0;
    logic              zero_bit = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    niosii_soc_onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata),
        .dbg_state(dbg_state), .dbg_owner(dbg_owner), .dbg_hold_cnt(dbg_hold_cnt)
    );

    niosii_soc_onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(1)) u_dut_h1 (
        .clk(clk), .reset_n(reset_n),
        .m0_address(zero_addr), .m0_byteenable(zero_be), .m0_read(h_m0_read),
        .m0_write(zero_bit), .m0_writedata(zero_data), .m0_waitrequest(h_m0_wait),
        .m0_readdata(h_m0_rdata), .m0_readdatavalid(h_m0_rdv),
        .m1_address(zero_addr), .m1_byteenable(zero_be), .m1_read(h_m1_read),
        .m1_write(zero_bit), .m1_writedata(zero_data), .m1_waitrequest(h_m1_wait),
        .m1_readdata(h_m1_rdata), .m1_readdatavalid(h_m1_rdv),
        .mem_address(h_mem_address), .mem_byteenable(h_mem_be), .mem_writedata(h_mem_wdata),
        .mem_chipselect(h_mem_cs), .mem_write(h_mem_write), .mem_clken(h_mem_clken),
        .mem_readdata(h_mem_rdata),
        .dbg_state(h_state), .dbg_owner(h_owner), .dbg_hold_cnt(h_hold)
    );

    // Memory slave model: registered read, byte-lane writes, preloaded during reset.
    always @(posedge clk) begin
        if (!reset_n) begin
            mem_model[16] <= 32'h1010_0010;
            mem_model[32] <= 32'h2020_0020;
        end else if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) mem_model[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end else begin
                mem_readdata <= mem_model[mem_address];
            end
        end
    end

    task automatic check_val(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // One driven cycle: check waitrequests, push expected returns for granted reads.
    task automatic step(input logic ew0, input logic ew1, input logic [DATA_W-1:0] ed0, input logic [DATA_W-1:0] ed1);
        @(negedge clk);
        check_val("m0_waitrequest", 32'(m0_waitrequest), 32'(ew0));
        check_val("m1_waitrequest", 32'(m1_waitrequest), 32'(ew1));
        if (reset_n && m0_read && !m0_write && !ew0) exp_q.push_back({16'(cyc + 1), 1'b0, ed0});
        if (reset_n && m1_read && !m1_write && !ew1) exp_q.push_back({16'(cyc + 1), 1'b1, ed1});
        @(posedge clk);
        #1;
    endtask

    task automatic step_h1(input logic ew0, input logic ew1);
        @(negedge clk);
        check_val("h1_m0_waitrequest", 32'(h_m0_wait), 32'(ew0));
        check_val("h1_m1_waitrequest", 32'(h_m1_wait), 32'(ew1));
        check_val("h1_chipselect", 32'(h_mem_cs), 32'(1));
        @(posedge clk);
        #1;
    endtask

    // Monitor: every readdatavalid must match the oldest expected return.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (m0_readdatavalid || m1_readdatavalid) begin
            checks++;
            if (m0_readdatavalid && m1_readdatavalid) begin
                errors++;
                $display("FAIL rdv_both cyc=%0d got both valid exp one", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdv_unexpected cyc=%0d got m0=%0b m1=%0b exp none", cyc, m0_readdatavalid, m1_readdatavalid);
            end else begin
                e = exp_q.pop_front();
                if (e[DATA_W+16 +: 1] == 1'b1) e = e; // keep e fully used below
                if ((16'(cyc) !== e[DATA_W+1 +: 16]) || (m1_readdatavalid !== e[DATA_W]) ||
                    ((m1_readdatavalid ? m1_readdata : m0_readdata) !== e[DATA_W-1:0])) begin
                    errors++;
                    $display("FAIL rd_return got cyc=%0d m1=%0b data=%0h exp cyc=%0d m1=%0b data=%0h",
                             cyc, m1_readdatavalid, m1_readdatavalid ? m1_readdata : m0_readdata,
                             e[DATA_W+1 +: 16], e[DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        m0_address = 13'h0010; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = '0;
        m1_address = 13'h0020; m1_byteenable = 4'hF; m1_read = 1'b1; m1_write = 1'b0; m1_writedata = '0;
        h_m0_read = 1'b0; h_m1_read = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_m0_wait", 32'(m0_waitrequest), 32'(1));
        check_val("rst_m1_wait", 32'(m1_waitrequest), 32'(1));
        check_val("rst_chipselect", 32'(mem_chipselect), 32'(0));
        check_val("rst_mem_write", 32'(mem_write), 32'(0));
        check_val("rst_clken", 32'(mem_clken), 32'(0));
        check_val("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'(0));
        check_val("rst_owner", 32'(dbg_owner), 32'(1));
        check_val("rst_hold_cnt", 32'(dbg_hold_cnt), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Continuous contention, MAX_HOLD = 4: m0 first, then blocks of 4.
        for (int k = 0; k < 16; k++) begin
            step(((k / 4) % 2) == 1, ((k / 4) % 2) == 0, 32'h1010_0010, 32'h2020_0020);
        end
        check_val("clken_run", 32'(mem_clken), 32'(1));
        m0_read = 1'b0; m1_read = 1'b0;
        step(1'b0, 1'b0, '0, '0);

        // Write then read at the top address.
        m0_write = 1'b1; m0_address = 13'h1FFF; m0_byteenable = 4'hF; m0_writedata = 32'hDEAD_BEEF;
        step(1'b0, 1'b0, '0, '0);
        m0_write = 1'b0; m0_read = 1'b1;
        step(1'b0, 1'b0, 32'hDEAD_BEEF, '0);
        m0_read = 1'b0;

        // Byte-lane merge on m1.
        m1_write = 1'b1; m1_address = 13'h0100; m1_byteenable = 4'hF; m1_writedata = 32'h1122_3344;
        step(1'b0, 1'b0, '0, '0);
        m1_byteenable = 4'h1; m1_writedata = 32'h0000_00AA;
        step(1'b0, 1'b0, '0, '0);
        m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF;
        step(1'b0, 1'b0, '0, 32'h1122_33AA);
        m1_read = 1'b0;

        // Read+write together is a write with no return.
        m0_read = 1'b1; m0_write = 1'b1; m0_address = 13'h0004; m0_writedata = 32'h5566_7788;
        @(negedge clk);
        check_val("rw_mem_write", 32'(mem_write), 32'(1));
        @(posedge clk);
        #1;
        m0_write = 1'b0;
        step(1'b0, 1'b0, 32'h5566_7788, '0);
        m0_read = 1'b0;
        step(1'b0, 1'b0, '0, '0);

        // Read issued in the cycle reset asserts.
        m0_read = 1'b1; m0_address = 13'h0010; reset_n = 1'b0;
        @(negedge clk);
        check_val("rstrd_m0_wait", 32'(m0_waitrequest), 32'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b1; m0_read = 1'b0;
        @(negedge clk);
        check_val("rstrd_owner", 32'(dbg_owner), 32'(1));
        check_val("rstrd_hold_cnt", 32'(dbg_hold_cnt), 32'(0));
        check_val("rstrd_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        m0_read = 1'b1; m1_read = 1'b1; m0_address = 13'h0010; m1_address = 13'h0020;
        step(1'b0, 1'b1, 32'h1010_0010, '0);
        m0_read = 1'b0; m1_read = 1'b0;
        step(1'b0, 1'b0, '0, '0);

        // MAX_HOLD = 1: sole requester never stalls, then strict alternation.
        h_m1_read = 1'b1;
        for (int k = 0; k < 10; k++) step_h1(1'b0, 1'b0);
        h_m0_read = 1'b1;
        for (int k = 0; k < 4; k++) step_h1((k % 2) == 1, (k % 2) == 0);
        h_m0_read = 1'b0; h_m1_read = 1'b0;

        @(negedge clk);
        check_val("exp_q_drained", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
